// File: rtl/trap_filter_v2.sv
// Trapezoidal shaper with pole-zero correction, rounding/saturation and a
// threshold peak detector. Six-stage pipeline; the datapath advances only on valid samples.
//
// state | meaning
// IDLE  | waiting for output_data to rise above threshold
// ABOVE | inside a pulse, tracking its maximum and width
module trap_filter_v2 #(
    parameter int SIZE_ADC_DATA    = 12,
    parameter int SIZE_FILTER_DATA = 16,
    parameter int SIZE_ACC         = 32,
    parameter int K                = 4,
    parameter int L                = 2,
    parameter int M                = 0,
    parameter int SHIFT            = 7,
    parameter int SIZE_WIDTH       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               in_valid,
    input  logic        [SIZE_ADC_DATA-1:0]    input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic                               out_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] output_data,
    output logic                               sat,
    output logic                               peak_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
    output logic        [SIZE_WIDTH-1:0]       peak_width
);

    localparam int NTAPS = K + L + 1;
    localparam logic signed [SIZE_ACC-1:0] M_S   = SIZE_ACC'(M);
    localparam logic signed [SIZE_ACC-1:0] ROUND = SIZE_ACC'((2 ** SHIFT) / 2);
    localparam logic signed [SIZE_ACC-1:0] MAXV  = SIZE_ACC'((2 ** (SIZE_FILTER_DATA - 1)) - 1);
    localparam logic signed [SIZE_ACC-1:0] MINV  = ~MAXV;

    typedef enum logic {IDLE, ABOVE} state_t;

    logic signed [SIZE_ACC-1:0] taps [NTAPS];
    logic signed [SIZE_ACC-1:0] x_ext;
    logic signed [SIZE_ACC-1:0] dkl, p, mdkl, r, s;
    logic                       v1, v2, v3, v4, v5;

    logic signed [SIZE_ACC-1:0]         rnd_sum, rnd_shift;
    logic signed [SIZE_FILTER_DATA-1:0] y_sat;
    logic                               clamp;

    state_t                             state, state_nxt;
    logic signed [SIZE_FILTER_DATA-1:0] max_val, max_nxt;
    logic        [SIZE_WIDTH-1:0]       wid_cnt, wid_nxt;
    logic                               report, above;

    assign x_ext = SIZE_ACC'(input_data);

    // Round half up, arithmetic shift, then clamp to the output range
    always_comb begin
        rnd_sum   = s + ROUND;
        rnd_shift = rnd_sum >>> SHIFT;
        y_sat     = rnd_shift[SIZE_FILTER_DATA-1:0];
        clamp     = 1'b0;
        if (rnd_shift > MAXV) begin
            y_sat = MAXV[SIZE_FILTER_DATA-1:0];
            clamp = 1'b1;
        end else if (rnd_shift < MINV) begin
            y_sat = MINV[SIZE_FILTER_DATA-1:0];
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            v5        <= 1'b0;
            out_valid <= 1'b0;
            dkl       <= '0;
            p         <= '0;
            mdkl      <= '0;
            r         <= '0;
            s         <= '0;
            sat       <= 1'b0;
            if (reset) output_data <= '0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            v5        <= v4;
            out_valid <= v5;
            if (in_valid) begin
                taps[0] <= x_ext;
                for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
            end
            if (v1) dkl <= taps[0] - taps[K] - taps[L] + taps[K+L];
            if (v2) begin
                p    <= p + dkl;
                mdkl <= dkl * M_S;
            end
            // p already holds this sample's update when v3 is high
            if (v3) r <= p + mdkl;
            if (v4) s <= s + r;
            if (v5) begin
                output_data <= y_sat;
                sat         <= sat | clamp;
            end
        end
    end

    assign above = (output_data > threshold);

    always_comb begin
        state_nxt = state;
        max_nxt   = max_val;
        wid_nxt   = wid_cnt;
        report    = 1'b0;
        if (out_valid) begin
            case (state)
                IDLE: begin
                    if (above) begin
                        state_nxt = ABOVE;
                        max_nxt   = output_data;
                        wid_nxt   = SIZE_WIDTH'(1);
                    end
                end
                ABOVE: begin
                    if (above) begin
                        if (output_data > max_val) max_nxt = output_data;
                        if (wid_cnt != '1) wid_nxt = wid_cnt + SIZE_WIDTH'(1);
                    end else begin
                        state_nxt = IDLE;
                        report    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            max_val    <= '0;
            wid_cnt    <= '0;
            peak_valid <= 1'b0;
            peak_value <= '0;
            peak_width <= '0;
        end else if (clear) begin
            state      <= IDLE;
            max_val    <= '0;
            wid_cnt    <= '0;
            peak_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            max_val    <= max_nxt;
            wid_cnt    <= wid_nxt;
            peak_valid <= report;
            if (report) begin
                peak_value <= max_val;
                peak_width <= wid_cnt;
            end
        end
    end

endmodule

// File: tb/tb_trap_filter_v2.sv
// Directed bench for trap_filter_v2: trapezoid shape, stalls, rounding,
// saturation, peak reporting, clear and mid-pulse reset.
module tb_trap_filter_v2;

    logic clk = 1'b0;
    logic reset, clear, in_valid;
    logic [11:0] input_data;

    logic signed [15:0] th0 = 16'sd150;
    logic signed [15:0] th1 = 16'sh7fff;
    logic signed [7:0]  th2 = 8'sh7f;

    logic               ov0, sat0, pv0;
    logic signed [15:0] od0, pval0;
    logic [7:0]         pw0;
    logic               ov1, sat1, pv1;
    logic signed [15:0] od1, pval1;
    logic [7:0]         pw1;
    logic               ov2, sat2, pv2;
    logic signed [7:0]  od2, pval2;
    logic [7:0]         pw2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int q0[$], qc0[$], q1[$], q2[$], in_c[$];
    int pkv[$], pkw[$], pkc[$];
    int exp_a [8] = '{100, 200, 200, 200, 100, 0, 0, 0};
    int exp_b [6] = '{51, 101, 101, 101, 51, 0};
    int exp_c [6] = '{127, 127, 127, 127, 127, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_filter_v2 #(.K(4), .L(2), .M(0), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .input_data(input_data), .threshold(th0), .out_valid(ov0),
        .output_data(od0), .sat(sat0), .peak_valid(pv0),
        .peak_value(pval0), .peak_width(pw0));

    trap_filter_v2 #(.K(4), .L(2), .M(0), .SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .input_data(input_data), .threshold(th1), .out_valid(ov1),
        .output_data(od1), .sat(sat1), .peak_valid(pv1),
        .peak_value(pval1), .peak_width(pw1));

    trap_filter_v2 #(.SIZE_FILTER_DATA(8), .K(4), .L(2), .M(0), .SHIFT(0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .input_data(input_data), .threshold(th2), .out_valid(ov2),
        .output_data(od2), .sat(sat2), .peak_valid(pv2),
        .peak_value(pval2), .peak_width(pw2));

    always @(negedge clk) begin
        if (ov0) begin
            q0.push_back(int'(od0));
            qc0.push_back(cyc);
        end
        if (ov1) q1.push_back(int'(od1));
        if (ov2) q2.push_back(int'(od2));
        if (pv0) begin
            pkv.push_back(int'(pval0));
            pkw.push_back(int'(pw0));
            pkc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -99999;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_q();
        q0.delete(); qc0.delete(); q1.delete(); q2.delete(); in_c.delete();
        pkv.delete(); pkw.delete(); pkc.delete();
    endtask

    task automatic run_imp(input int amp, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            in_valid   = 1'b1;
            input_data = (i == 0) ? 12'(amp) : 12'd0;
            in_c.push_back(cyc);
            for (int j = 1; j < period; j++) begin
                tick();
                in_valid = 1'b0;
            end
        end
        tick();
        in_valid   = 1'b0;
        input_data = 12'd0;
        repeat (12) tick();
    endtask

    task automatic pulse_clear();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_trap(input string tag, input int period);
        chk({tag, "_cnt"}, q0.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_val"}, qget(q0, i), exp_a[i]);
            chk({tag, "_lat"}, qget(qc0, i) - qget(in_c, i), 6);
            if (i > 0) chk({tag, "_gap"}, qget(qc0, i) - qget(qc0, i - 1), period);
        end
    endtask

    task automatic check_peak(input string tag);
        chk({tag, "_pk_cnt"}, pkv.size(), 1);
        chk({tag, "_pk_val"}, qget(pkv, 0), 200);
        chk({tag, "_pk_wid"}, qget(pkw, 0), 3);
        chk({tag, "_pk_when"}, qget(pkc, 0) - qget(qc0, 4), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int i;
        bit hit;
        int acc;
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        input_data = 12'd0;
        repeat (3) tick();
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_output_data", int'(od0), 0);
        chk("rst_sat", int'(sat0), 0);
        chk("rst_peak_valid", int'(pv0), 0);
        chk("rst_peak_value", int'(pval0), 0);
        chk("rst_peak_width", int'(pw0), 0);
        reset = 1'b0;
        repeat (2) tick();

        // continuous trapezoid with peak detection
        clr_q();
        run_imp(100, 1, 8);
        check_trap("trap", 1);
        check_peak("trap");
        chk("trap_no_sat", int'(sat0), 0);

        // one sample every third clock
        clr_q();
        run_imp(100, 3, 8);
        check_trap("stall", 3);

        // rounding with SHIFT=1
        clr_q();
        run_imp(101, 1, 8);
        for (int k = 0; k < 6; k++) chk("round_val", qget(q1, k), exp_b[k]);

        // saturation on the 8-bit instance, sticky until clear
        pulse_clear();
        chk("sat_cleared_pre", int'(sat2), 0);
        clr_q();
        run_imp(2000, 1, 8);
        for (int k = 0; k < 6; k++) chk("sat_val", qget(q2, k), exp_c[k]);
        chk("sat_wide_val", qget(q0, 1), 4000);
        chk("sat_set", int'(sat2), 1);
        chk("sat_wide_clear", int'(sat0), 0);
        repeat (5) tick();
        chk("sat_sticky", int'(sat2), 1);
        pulse_clear();
        chk("sat_cleared", int'(sat2), 0);

        // clear coincident with a sample drops that sample
        clr_q();
        tick();
        clear = 1'b1;
        in_valid = 1'b1;
        input_data = 12'd100;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        input_data = 12'd0;
        run_imp(0, 1, 7);
        chk("clr_drop_cnt", q0.size(), 7);
        acc = 0;
        foreach (q0[k]) acc += (q0[k] < 0) ? -q0[k] : q0[k];
        chk("clr_drop_sum", acc, 0);

        // reset on the third output of a pulse
        clr_q();
        i = 0;
        hit = 1'b0;
        while (!hit && i < 20) begin
            tick();
            if (q0.size() == 3) begin
                reset = 1'b1;
                in_valid = 1'b0;
                input_data = 12'd0;
                hit = 1'b1;
            end else begin
                in_valid = (i < 8);
                input_data = (i == 0) ? 12'd100 : 12'd0;
                i++;
            end
        end
        chk("rstmid_hit", int'(hit), 1);
        chk("rstmid_third", qget(q0, 2), 200);
        tick();
        chk("rstmid_out_valid", int'(ov0), 0);
        chk("rstmid_output_data", int'(od0), 0);
        chk("rstmid_peak_valid", int'(pv0), 0);
        chk("rstmid_peak_value", int'(pval0), 0);
        chk("rstmid_peak_width", int'(pw0), 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("rstmid_no_peak", pkv.size(), 0);
        clr_q();
        run_imp(100, 1, 8);
        check_trap("rerun", 1);
        check_peak("rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trap_filter_v2.md
TRAP_FILTER_V2 -- requirements
Module: trap_filter_v2

Interface
REQ-001 Parameter SIZE_ADC_DATA, default 12: input sample width, unsigned.
REQ-002 Parameter SIZE_FILTER_DATA, default 16: output width, signed.
REQ-003 Parameter SIZE_ACC, default 32: width of all internal signed datapath registers.
REQ-004 Parameter K, default 4: long delay; L, default 2: short delay; constraint 1 <= L <= K.
REQ-005 Parameter M, default 0: unsigned pole-zero multiplier, at most 16 bits.
REQ-006 Parameter SHIFT, default 7: output right-shift, range 0..16.
REQ-007 Parameter SIZE_WIDTH, default 8: width of the peak-width counter.
REQ-008 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-009 Port reset, input, 1: synchronous reset, active-high.
REQ-010 Port clear, input, 1: synchronous flush of accumulators and peak FSM.
REQ-011 Port in_valid, input, 1: input_data is a new sample this cycle.
REQ-012 Port input_data, input, SIZE_ADC_DATA: ADC sample, unsigned, zero-extended internally.
REQ-013 Port threshold, input, SIZE_FILTER_DATA: signed peak-detect threshold.
REQ-014 Port out_valid, output, 1: output_data holds a new filtered sample.
REQ-015 Port output_data, output, SIZE_FILTER_DATA: signed filtered sample.
REQ-016 Port sat, output, 1: sticky flag, set when output_data was clamped.
REQ-017 Port peak_valid, output, 1: one-cycle strobe when a peak is reported.
REQ-018 Port peak_value, output, SIZE_FILTER_DATA: maximum output_data over the pulse.
REQ-019 Port peak_width, output, SIZE_WIDTH: number of samples above threshold, saturating.

Function
REQ-020 The delay line (K+L+1 taps) shifts only on in_valid; stall cycles change no datapath state.
REQ-021 Each stage carries a valid bit; out_valid rises exactly 6 clocks after the in_valid that produced it.
REQ-022 S1: capture x[n]. S2: dkl = x[n]-x[n-K]-x[n-L]+x[n-K-L].
REQ-023 S3: p <= p+dkl, and mdkl <= M*dkl registered.
REQ-024 S4: r = p_updated + mdkl, where p_updated is the S3 result for the same sample.
REQ-025 S5: s <= s+r.
REQ-026 S6: rounding and saturation (REQ-028, REQ-029).
REQ-027 p and s update only when their stage valid bit is 1; arithmetic is SIZE_ACC two's-complement and wraps silently.
REQ-028 Rounding: y = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift; when SHIFT=0, y = s.
REQ-029 Saturation: y is clamped to [-2^(SIZE_FILTER_DATA-1), 2^(SIZE_FILTER_DATA-1)-1]; a clamp sets sat, which clears only on reset or clear.
REQ-030 output_data holds its value between out_valid pulses.
REQ-031 Peak FSM states: IDLE and ABOVE, evaluated only on out_valid.
REQ-032 IDLE->ABOVE when output_data > threshold; this loads max=output_data and width=1.
REQ-033 In ABOVE, while output_data > threshold: max=max(max, output_data) and width+1, saturating at all-ones.
REQ-034 ABOVE->IDLE when output_data <= threshold; the next clock peak_valid=1 with peak_value=max and peak_width=width.
REQ-035 peak_value and peak_width hold until the next report.
REQ-036 clear zeros p, s, mdkl, delay taps, stage valids, sat and FSM (to IDLE) on the next clock, with no peak report.
REQ-037 clear has priority over a simultaneous in_valid; that sample is dropped.

Reset
REQ-038 On reset=1 at a clock edge, all registers zero: output_data=0, out_valid=0, sat=0, peak_valid=0, peak_value=0, peak_width=0, FSM=IDLE.
REQ-039 reset overrides clear and in_valid; reset during a pulse aborts it with no peak report.
REQ-040 After reset deasserts, the first out_valid occurs 6 clocks after the first in_valid.

Verification
REQ-041 Trapezoid: K=4, L=2, M=0, SHIFT=0, impulse 100 then zeros, in_valid every cycle -> output_data 100,200,200,200,100,0; first value 6 clocks after the impulse.
REQ-042 Stalls: same stimulus with in_valid every 3rd cycle -> same output sequence; out_valid spacing 3 clocks; each value 6 clocks after its sample.
REQ-043 Rounding: SHIFT=1, impulse 101 -> first output 51, then 101.
REQ-044 Saturation: SIZE_FILTER_DATA=8, SHIFT=0, impulse 2000 -> outputs clamped to 127; sat=1 until clear.
REQ-045 Peak: REQ-041 stimulus with threshold 150 -> one peak_valid pulse, peak_value=200, peak_width=3.
REQ-046 Reset mid-pulse: assert reset on the 3rd output of REQ-041 -> next clock all outputs 0, no peak_valid; a later impulse reproduces REQ-041 exactly.
